vga_frame_mux: RTL and testbench

VGA_FRAME_MUX -- requirements
Module: vga_frame_mux

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_frame_mux.sv | 175 +++++++++++++++++
 tb/tb_vga_frame_mux.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame multiplexer.
//   PIXEL_WIDTH  : pixel word width, {R8,2'b0,G8,2'b0,B8,2'b0}
//   FRAME_PIXELS : active pixels in one 640x480 frame
//   mux_state_t  : SYNC (hunting for a start-of-frame) / PASS (forwarding a frame)
package vga_pkg;

    localparam int PIXEL_WIDTH  = 30;
    localparam int FRAME_PIXELS = 307200;

    typedef enum logic {
        SYNC = 1'b0,
        PASS = 1'b1
    } mux_state_t;

endpackage

// File: rtl/vga_frame_mux.sv
// Frame-aligned multiplexer for Avalon-ST pixel streams.
// One source at a time is routed combinationally to the output. Source
// changes only take effect on frame boundaries: a request made mid-frame is
// held pending until the active source's EOP, after which the mux drops
// beats from the new source until its next SOP.
//
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   src_data/_startofpacket/
//   src_endofpacket/src_valid   : per-source Avalon-ST sink inputs
//   src_ready                   : per-source ready (0 for non-active sources)
//   out_data/_startofpacket/
//   out_endofpacket/out_valid   : routed Avalon-ST source output
//   out_ready                   : downstream ready
//   sel_req, sel_in             : one-cycle source change request and index
//   active_sel                  : currently routed source
//   switch_pending              : a request is waiting for the frame to end
//   frame_count                 : completed output frames (wraps)
module vga_frame_mux
    import vga_pkg::*;
#(
    parameter  int NUM_SOURCES = 4,
    parameter  int DATA_WIDTH  = PIXEL_WIDTH,
    localparam int SEL_W       = $clog2(NUM_SOURCES),
    localparam int FC_W        = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SOURCES-1:0]                src_startofpacket,
    input  logic [NUM_SOURCES-1:0]                src_endofpacket,
    input  logic [NUM_SOURCES-1:0]                src_valid,
    output logic [NUM_SOURCES-1:0]                src_ready,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  out_startofpacket,
    output logic                                  out_endofpacket,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    input  logic                                  sel_req,
    input  logic [SEL_W-1:0]                      sel_in,
    output logic [SEL_W-1:0]                      active_sel,
    output logic                                  switch_pending,
    output logic [FC_W-1:0]                       frame_count
);

    localparam logic [SEL_W:0] NUM_SRC = (SEL_W+1)'(NUM_SOURCES);

    mux_state_t        r_state, w_state_next;
    logic [SEL_W-1:0]  r_active, w_active_next;
    logic [SEL_W-1:0]  r_pend_idx, w_pend_idx_next;
    logic              r_pend_valid, w_pend_valid_next;
    logic [FC_W-1:0]   r_frame_count, w_frame_count_next;

    logic [DATA_WIDTH-1:0] w_act_data;
    logic              w_act_sop, w_act_eop, w_act_valid, w_act_ready;
    logic              w_hs, w_sel_ok, w_sel_same;

    // Zero-latency routing of the active source.
    always_comb begin
        w_act_data  = '0;
        w_act_sop   = 1'b0;
        w_act_eop   = 1'b0;
        w_act_valid = 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (r_active == SEL_W'(i)) begin
                w_act_data  = src_data[i];
                w_act_sop   = src_startofpacket[i];
                w_act_eop   = src_endofpacket[i];
                w_act_valid = src_valid[i];
            end
        end
    end

    // Only the active source ever sees ready; the others stall in place.
    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_ready
            assign src_ready[gi] = (r_active == SEL_W'(gi)) && w_act_ready;
        end
    endgenerate

    assign out_data          = w_act_data;
    assign out_startofpacket = w_act_sop;
    assign out_endofpacket   = w_act_eop;
    assign active_sel        = r_active;
    assign switch_pending    = r_pend_valid;
    assign frame_count       = r_frame_count;

    assign w_hs       = out_valid && out_ready;
    assign w_sel_ok   = sel_req && ({1'b0, sel_in} < NUM_SRC);
    assign w_sel_same = (sel_in == r_active);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= SYNC;
            r_active      <= '0;
            r_pend_idx    <= '0;
            r_pend_valid  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_active      <= w_active_next;
            r_pend_idx    <= w_pend_idx_next;
            r_pend_valid  <= w_pend_valid_next;
            r_frame_count <= w_frame_count_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next       = r_state;
        w_active_next      = r_active;
        w_pend_idx_next    = r_pend_idx;
        w_pend_valid_next  = r_pend_valid;
        w_frame_count_next = r_frame_count;
        case (r_state)
            SYNC: begin
                if (w_hs) begin
                    // The SOP of the current source has been accepted, so a
                    // frame is now in flight; a request arriving on the same
                    // edge must wait for that frame's EOP like any other.
                    w_state_next = PASS;
                    if (w_sel_ok && !w_sel_same) begin
                        w_pend_valid_next = 1'b1;
                        w_pend_idx_next   = sel_in;
                    end
                end else if (w_sel_ok) begin
                    // No frame in progress: switch immediately.
                    w_active_next = sel_in;
                end
            end
            PASS: begin
                if (w_hs && w_act_eop) begin
                    w_frame_count_next = r_frame_count + 1'b1;
                    w_pend_valid_next  = 1'b0;
                    // A request on the EOP edge overrides any older one.
                    if (w_sel_ok) begin
                        if (!w_sel_same) begin
                            w_active_next = sel_in;
                            w_state_next  = SYNC;
                        end
                    end else if (r_pend_valid) begin
                        w_active_next = r_pend_idx;
                        w_state_next  = SYNC;
                    end
                end else if (w_sel_ok) begin
                    // Re-selecting the live source cancels a queued switch.
                    w_pend_valid_next = !w_sel_same;
                    w_pend_idx_next   = sel_in;
                end
            end
            default: w_state_next = SYNC;
        endcase
    end

    // Output logic: SYNC discards non-SOP beats, PASS forwards everything.
    always_comb begin
        out_valid   = 1'b0;
        w_act_ready = 1'b0;
        if (!reset) begin
            case (r_state)
                SYNC: begin
                    out_valid   = w_act_valid && w_act_sop;
                    w_act_ready = w_act_sop ? out_ready : 1'b1;
                end
                PASS: begin
                    out_valid   = w_act_valid;
                    w_act_ready = out_ready;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_mux.sv
// Randomized scoreboard bench for vga_frame_mux (5 sources so that
// out-of-range indices 5..7 are representable on sel_in).
module tb_vga_frame_mux;

    localparam int NS = 5;
    localparam int DW = 30;
    localparam int SW = $clog2(NS);

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NS-1:0][DW-1:0]  src_data;
    logic [NS-1:0]          src_sop, src_eop, src_valid, src_ready;
    logic [DW-1:0]          out_data;
    logic                   out_sop, out_eop, out_valid, out_ready;
    logic                   sel_req;
    logic [SW-1:0]          sel_in, active_sel;
    logic                   switch_pending;
    logic [15:0]            frame_count;

    vga_frame_mux #(.NUM_SOURCES(NS), .DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .src_data          (src_data),
        .src_startofpacket (src_sop),
        .src_endofpacket   (src_eop),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .out_data          (out_data),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .sel_req           (sel_req),
        .sel_in            (sel_in),
        .active_sel        (active_sel),
        .switch_pending    (switch_pending),
        .frame_count       (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    beat_t srcq [NS][$];   // pending beats of each source stream
    beat_t expq [$];       // expected output beats

    int n_checks = 0;
    int n_pass   = 0;
    int n_beats  = 0;

    // stimulus knobs
    bit rst_knob;
    int vprob, rmode, selprob, force_sel;
    bit tog;

    // reference model: mode, routed source, pending index (-1 = none), frames
    bit m_sync;
    int m_active, m_pend, m_fc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic add_frame(input int s, input int junk);
        beat_t b;
        int len;
        len = $urandom_range(2, 8);
        for (int j = 0; j < junk; j++) begin
            b.data = DW'($urandom());
            b.sop  = 1'b0;
            b.eop  = 1'($urandom_range(0, 1));
            srcq[s].push_back(b);
        end
        for (int j = 0; j < len; j++) begin
            b.data = DW'($urandom());
            // occasional stray SOP inside a frame
            b.sop  = (j == 0) || (j < len - 1 && $urandom_range(0, 15) == 0);
            b.eop  = (j == len - 1);
            srcq[s].push_back(b);
        end
    endtask

    task automatic cycle();
        logic [NS-1:0] exp_ready, dut_ready;
        bit exp_valid, hs, sel_ok;
        int a, target, sel_v;
        beat_t h;
        @(negedge clk);
        reset = rst_knob;
        tog   = ~tog;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 99) < 75);
            default: out_ready = tog;
        endcase
        if (force_sel >= 0) begin
            sel_req = 1'b1;
            sel_in  = SW'(force_sel);
        end else begin
            sel_req = ($urandom_range(0, 99) < selprob);
            sel_in  = SW'($urandom_range(0, 7));
        end
        force_sel = -1;
        for (int s = 0; s < NS; s++) begin
            if (srcq[s].size() < 2)
                add_frame(s, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
            src_data[s]  = srcq[s][0].data;
            src_sop[s]   = srcq[s][0].sop;
            src_eop[s]   = srcq[s][0].eop;
            src_valid[s] = ($urandom_range(0, 99) < vprob);
        end
        #1;
        a         = m_active;
        h         = srcq[a][0];
        exp_ready = '0;
        exp_valid = 1'b0;
        if (!rst_knob) begin
            if (m_sync) begin
                exp_valid    = src_valid[a] && h.sop;
                exp_ready[a] = h.sop ? out_ready : 1'b1;
            end else begin
                exp_valid    = src_valid[a];
                exp_ready[a] = out_ready;
            end
        end
        hs = exp_valid && out_ready;
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("src_ready", 64'(src_ready), 64'(exp_ready));
        check("active_sel", 64'(active_sel), 64'(m_active));
        check("switch_pending", 64'(switch_pending), 64'(m_pend >= 0));
        check("frame_count", 64'(frame_count), 64'(m_fc));
        if (hs) expq.push_back(h);
        dut_ready = src_ready;
        sel_v  = int'(sel_in);
        sel_ok = sel_req && (sel_v < NS);
        @(posedge clk);
        if (rst_knob) begin
            m_sync = 1'b1; m_active = 0; m_pend = -1; m_fc = 0;
        end else if (m_sync) begin
            if (hs) begin
                m_sync = 1'b0;
                if (sel_ok && sel_v != m_active) m_pend = sel_v;
            end else if (sel_ok) begin
                m_active = sel_v;
            end
        end else begin
            if (hs && h.eop) begin
                m_fc   = (m_fc + 1) % 65536;
                target = sel_ok ? sel_v : m_pend;
                m_pend = -1;
                if (target >= 0 && target != m_active) begin
                    m_active = target;
                    m_sync   = 1'b1;
                end
            end else if (sel_ok) begin
                m_pend = (sel_v == m_active) ? -1 : sel_v;
            end
        end
        for (int s = 0; s < NS; s++)
            if (src_valid[s] && dut_ready[s]) void'(srcq[s].pop_front());
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes an output beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready) begin
                n_beats++;
                $display("beat %0d: src=%0d data=%h sop=%0b eop=%0b frames=%0d",
                         n_beats, active_sel, out_data, out_sop, out_eop, frame_count);
                if (expq.size() == 0) begin
                    check("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    e = expq.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_sop", 64'(out_sop), 64'(e.sop));
                    check("out_eop", 64'(out_eop), 64'(e.eop));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; out_ready = 1'b0; sel_req = 1'b0; sel_in = '0;
        src_data = '0; src_sop = '0; src_eop = '0; src_valid = '0;
        rst_knob = 1'b1; vprob = 100; rmode = 0; selprob = 0; force_sel = -1; tog = 1'b0;
        m_sync = 1'b1; m_active = 0; m_pend = -1; m_fc = 0;
        repeat (3) cycle();

        // five leading non-SOP beats on source 0 are dropped, then a frame
        srcq[0].delete();
        add_frame(0, 5);
        rst_knob = 1'b0;
        repeat (8) cycle();

        // mid-frame request for source 2
        force_sel = 2; cycle();
        repeat (12) cycle();

        // requests 1 then 3 before EOP; then a request equal to active
        force_sel = 1; cycle();
        force_sel = 3; cycle();
        repeat (15) cycle();
        force_sel = m_active; cycle();
        repeat (10) cycle();

        // randomized traffic and requests
        vprob = 80; rmode = 1; selprob = 4;
        repeat (600) cycle();

        // out_ready toggling every cycle
        rmode = 2;
        repeat (300) cycle();

        // out-of-range requests
        force_sel = 5; cycle();
        force_sel = 7; cycle();
        repeat (20) cycle();

        // reset in the middle of traffic, then resynchronise on source 0
        rmode = 1;
        repeat (37) cycle();
        rst_knob = 1'b1;
        repeat (2) cycle();
        rst_knob = 1'b0;
        repeat (300) cycle();

        @(negedge clk);
        #3;
        check("scoreboard_empty", 64'(expq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
